// File: rtl/memwb_pipe.sv
// ---------------------------------------------------------------------------
// memwb_pipe
//
// MEM/WB pipeline register for the MIPS datapath. Carries the writeback
// control and data fields from the data-memory stage to the register-file
// writeback through DEPTH register stages. It has these features:
//   - stall (hold) and flush (bubble) control
//   - a valid bit for each entry
//   - the final writeback-data mux
//   - suppression of writes to $zero
//   - a retired-instruction counter
//
// Parameters:
//   DATA_W  width of ReadData / ALUResult / WriteData
//   REG_W   register-address width
//   DEPTH   number of register stages, legal range 1..4
//   CNT_W   retired-counter width (wraps, no saturation)
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   MEM_Valid       MEM-side entry holds a real instruction
//   MEM_Stall       freeze every stage
//   MEM_Flush       turn every stage into a bubble (wins over stall)
//   MEM_MemtoReg    select memory data for writeback
//   MEM_RegWrite    instruction writes the register file
//   MEM_RegDst      destination register
//   MEM_ReadData    data-memory read value
//   MEM_ALUResult   ALU result
//   WB_Valid        last stage holds a real instruction
//   WB_MemtoReg     registered MemtoReg of the last stage
//   WB_RegWrite     write enable, qualified by valid and RegDst != 0
//   WB_RegDst       registered destination
//   WB_ReadData     registered read data
//   WB_ALUResult    registered ALU result
//   WB_WriteData    WB_MemtoReg ? WB_ReadData : WB_ALUResult
//   WB_Retired      count of retired instructions
//
// Flow control: there is no ready signal. An entry moves one stage on each
// edge where MEM_Stall=0 and MEM_Flush=0. MEM_Valid marks whether the
// captured entry is real or a bubble. Bubbles move like any other entry.
// A stall holds every stage. A flush clears the valid and control bits of
// every stage and does not capture the input.
// ---------------------------------------------------------------------------
module memwb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_Valid,
    input  logic              MEM_Stall,
    input  logic              MEM_Flush,
    input  logic              MEM_MemtoReg,
    input  logic              MEM_RegWrite,
    input  logic [REG_W-1:0]  MEM_RegDst,
    input  logic [DATA_W-1:0] MEM_ReadData,
    input  logic [DATA_W-1:0] MEM_ALUResult,
    output logic              WB_Valid,
    output logic              WB_MemtoReg,
    output logic              WB_RegWrite,
    output logic [REG_W-1:0]  WB_RegDst,
    output logic [DATA_W-1:0] WB_ReadData,
    output logic [DATA_W-1:0] WB_ALUResult,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic [CNT_W-1:0]  WB_Retired
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("memwb_pipe: DEPTH must be in the range 1..4");
    end

    typedef struct packed {
        logic              valid;
        logic              memtoreg;
        logic              regwrite;
        logic [REG_W-1:0]  regdst;
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] aluresult;
    } entry_t;

    entry_t             stage_q [DEPTH];
    entry_t             stage_d [DEPTH];
    entry_t             wb;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               retire;

    assign wb = stage_q[DEPTH-1];

    always_comb begin
        stage_d = stage_q;
        if (MEM_Flush) begin
            // RegDst and the data fields keep their old values. Only the
            // fields that could cause a commit are cleared.
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i].valid    = 1'b0;
                stage_d[i].memtoreg = 1'b0;
                stage_d[i].regwrite = 1'b0;
            end
        end else if (!MEM_Stall) begin
            stage_d[0].valid     = MEM_Valid;
            stage_d[0].memtoreg  = MEM_MemtoReg;
            stage_d[0].regwrite  = MEM_RegWrite;
            stage_d[0].regdst    = MEM_RegDst;
            stage_d[0].readdata  = MEM_ReadData;
            stage_d[0].aluresult = MEM_ALUResult;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // The WB entry is the oldest one in flight, so it commits even when a
    // flush arrives on the same edge. A stall on its own holds it in place.
    assign retire    = wb.valid & (MEM_Flush | ~MEM_Stall);
    assign retired_d = retired_q + CNT_W'(retire);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            retired_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            retired_q <= retired_d;
        end
    end

    assign WB_Valid     = wb.valid;
    assign WB_MemtoReg  = wb.memtoreg;
    assign WB_RegWrite  = wb.regwrite & wb.valid & (wb.regdst != '0);
    assign WB_RegDst    = wb.regdst;
    assign WB_ReadData  = wb.readdata;
    assign WB_ALUResult = wb.aluresult;
    assign WB_WriteData = wb.memtoreg ? wb.readdata : wb.aluresult;
    assign WB_Retired   = retired_q;

endmodule

// File: tb/tb_memwb_pipe.sv
// ---------------------------------------------------------------------------
// tb_memwb_pipe
//
// Directed bench for memwb_pipe. It builds three instances that share the
// same stimulus:
//   u_d1  DEPTH=1, CNT_W=32
//   u_d2  DEPTH=2, CNT_W=32
//   u_d4  DEPTH=4, CNT_W=4
// Each phase starts from reset and checks only the instance it targets.
// ---------------------------------------------------------------------------
module tb_memwb_pipe;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_stall;
    logic        mem_flush;
    logic        mem_memtoreg;
    logic        mem_regwrite;
    logic [4:0]  mem_regdst;
    logic [31:0] mem_readdata;
    logic [31:0] mem_aluresult;

    logic        d1_valid, d1_mtr, d1_rw;
    logic [4:0]  d1_dst;
    logic [31:0] d1_rd, d1_alu, d1_wd, d1_ret;

    logic        d2_valid, d2_mtr, d2_rw;
    logic [4:0]  d2_dst;
    logic [31:0] d2_rd, d2_alu, d2_wd, d2_ret;

    logic        d4_valid, d4_mtr, d4_rw;
    logic [4:0]  d4_dst;
    logic [31:0] d4_rd, d4_alu, d4_wd;
    logic [3:0]  d4_ret;

    int checks = 0;
    int errors = 0;

    memwb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(1), .CNT_W(32)) u_d1 (
        .clk(clk), .reset(reset), .MEM_Valid(mem_valid), .MEM_Stall(mem_stall),
        .MEM_Flush(mem_flush), .MEM_MemtoReg(mem_memtoreg), .MEM_RegWrite(mem_regwrite),
        .MEM_RegDst(mem_regdst), .MEM_ReadData(mem_readdata), .MEM_ALUResult(mem_aluresult),
        .WB_Valid(d1_valid), .WB_MemtoReg(d1_mtr), .WB_RegWrite(d1_rw), .WB_RegDst(d1_dst),
        .WB_ReadData(d1_rd), .WB_ALUResult(d1_alu), .WB_WriteData(d1_wd), .WB_Retired(d1_ret)
    );

    memwb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(2), .CNT_W(32)) u_d2 (
        .clk(clk), .reset(reset), .MEM_Valid(mem_valid), .MEM_Stall(mem_stall),
        .MEM_Flush(mem_flush), .MEM_MemtoReg(mem_memtoreg), .MEM_RegWrite(mem_regwrite),
        .MEM_RegDst(mem_regdst), .MEM_ReadData(mem_readdata), .MEM_ALUResult(mem_aluresult),
        .WB_Valid(d2_valid), .WB_MemtoReg(d2_mtr), .WB_RegWrite(d2_rw), .WB_RegDst(d2_dst),
        .WB_ReadData(d2_rd), .WB_ALUResult(d2_alu), .WB_WriteData(d2_wd), .WB_Retired(d2_ret)
    );

    memwb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(4), .CNT_W(4)) u_d4 (
        .clk(clk), .reset(reset), .MEM_Valid(mem_valid), .MEM_Stall(mem_stall),
        .MEM_Flush(mem_flush), .MEM_MemtoReg(mem_memtoreg), .MEM_RegWrite(mem_regwrite),
        .MEM_RegDst(mem_regdst), .MEM_ReadData(mem_readdata), .MEM_ALUResult(mem_aluresult),
        .WB_Valid(d4_valid), .WB_MemtoReg(d4_mtr), .WB_RegWrite(d4_rw), .WB_RegDst(d4_dst),
        .WB_ReadData(d4_rd), .WB_ALUResult(d4_alu), .WB_WriteData(d4_wd), .WB_Retired(d4_ret)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- driver tasks ----
    // Advance one rising edge, then settle 1 time unit past it. Outputs are
    // sampled and inputs are changed there, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mtr, input logic rw,
                         input logic [4:0] dst, input logic [31:0] rd,
                         input logic [31:0] alu);
        mem_valid     = v;
        mem_memtoreg  = mtr;
        mem_regwrite  = rw;
        mem_regdst    = dst;
        mem_readdata  = rd;
        mem_aluresult = alu;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_stall = 1'b0;
        mem_flush = 1'b0;
        idle();
        step();
        step();

        // ---- reset values ----
        chk("rst_d1_valid", 64'(d1_valid), 64'd0);
        chk("rst_d1_mtr",   64'(d1_mtr),   64'd0);
        chk("rst_d1_rw",    64'(d1_rw),    64'd0);
        chk("rst_d1_dst",   64'(d1_dst),   64'd0);
        chk("rst_d1_rd",    64'(d1_rd),    64'd0);
        chk("rst_d1_alu",   64'(d1_alu),   64'd0);
        chk("rst_d1_wd",    64'(d1_wd),    64'd0);
        chk("rst_d1_ret",   64'(d1_ret),   64'd0);
        chk("rst_d4_ret",   64'(d4_ret),   64'd0);
        reset = 1'b0;

        // ---- DEPTH=1 stream: ALU result writeback ----
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h1234);
        step();
        chk("d1_valid",   64'(d1_valid), 64'd1);
        chk("d1_rw",      64'(d1_rw),    64'd1);
        chk("d1_dst",     64'(d1_dst),   64'd8);
        chk("d1_wd_alu",  64'(d1_wd),    64'h1234);
        chk("d1_ret_0",   64'(d1_ret),   64'd0);
        idle();
        step();
        chk("d1_ret_1",   64'(d1_ret),   64'd1);
        chk("d1_bubble",  64'(d1_valid), 64'd0);

        // ---- $zero suppression ----
        drive(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 32'h55);
        step();
        chk("zero_valid", 64'(d1_valid), 64'd1);
        chk("zero_rw",    64'(d1_rw),    64'd0);
        idle();
        step();
        chk("zero_ret",   64'(d1_ret),   64'd2);

        // ---- flush and stall on the same edge ----
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE, 32'h77);
        step();
        chk("fs_pre_valid", 64'(d1_valid), 64'd1);
        chk("fs_pre_wd",    64'(d1_wd),    64'hCAFE);
        idle();
        mem_flush = 1'b1;
        mem_stall = 1'b1;
        step();
        mem_flush = 1'b0;
        mem_stall = 1'b0;
        chk("fs_valid",   64'(d1_valid), 64'd0);
        chk("fs_rw",      64'(d1_rw),    64'd0);
        chk("fs_mtr",     64'(d1_mtr),   64'd0);
        chk("fs_dst_kept",64'(d1_dst),   64'd9);
        chk("fs_wd_alu",  64'(d1_wd),    64'h77);
        chk("fs_ret",     64'(d1_ret),   64'd3);

        // ---- DEPTH=2 load path with stall ----
        pulse_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h11);
        step();                       // capture edge
        idle();
        mem_stall = 1'b1;
        step();
        step();
        step();                       // three stall edges
        chk("ld_stall_valid", 64'(d2_valid), 64'd0);
        chk("ld_stall_ret",   64'(d2_ret),   64'd0);
        mem_stall = 1'b0;
        step();                       // fifth edge: entry reaches WB
        chk("ld_valid",   64'(d2_valid), 64'd1);
        chk("ld_mtr",     64'(d2_mtr),   64'd1);
        chk("ld_wd",      64'(d2_wd),    64'hDEADBEEF);
        chk("ld_ret_0",   64'(d2_ret),   64'd0);
        mem_stall = 1'b1;
        step();
        chk("ld_hold_valid", 64'(d2_valid), 64'd1);
        chk("ld_hold_ret",   64'(d2_ret),   64'd0);
        mem_stall = 1'b0;
        step();
        chk("ld_ret_1",   64'(d2_ret),   64'd1);
        chk("ld_drain",   64'(d2_valid), 64'd0);

        // ---- DEPTH=4 fill, then reset mid-stream ----
        pulse_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(k), 32'h0, 32'h100 + 32'(k));
            step();
        end
        chk("fill_valid", 64'(d4_valid), 64'd1);
        chk("fill_wd",    64'(d4_wd),    64'h101);
        chk("fill_dst",   64'(d4_dst),   64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", 64'(d4_valid), 64'd0);
        chk("mrst_rw",    64'(d4_rw),    64'd0);
        chk("mrst_dst",   64'(d4_dst),   64'd0);
        chk("mrst_rd",    64'(d4_rd),    64'd0);
        chk("mrst_alu",   64'(d4_alu),   64'd0);
        chk("mrst_ret",   64'(d4_ret),   64'd0);
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'hABC);
        step();                       // first capture after reset
        idle();
        step();
        step();
        chk("lat_early",  64'(d4_valid), 64'd0);
        step();                       // fourth edge after capture started
        chk("lat_valid",  64'(d4_valid), 64'd1);
        chk("lat_dst",    64'(d4_dst),   64'd5);
        chk("lat_wd",     64'(d4_wd),    64'hABC);

        // ---- counter wrap with CNT_W=4 ----
        pulse_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'(k));
            step();
        end
        idle();
        step();
        step();
        step();
        chk("wrap_16", 64'(d4_ret), 64'd0);
        step();
        chk("wrap_17", 64'(d4_ret), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memwb_pipe.md
# memwb_pipe

Parametrised MEM/WB pipeline register for the MIPS datapath, between the data-memory stage and register-file writeback. It adds four things a plain stage register lacks: synchronous reset, stall (hold) and flush (bubble) control, per-entry valid tracking, and a configurable delay depth. It also provides the final writeback-data mux, $zero write suppression, and a retired-instruction counter for the hazard unit and performance debug.

## Interface
Parameters:
- DATA_W, 32, width of ReadData / ALUResult / WriteData
- REG_W, 5, register-address width
- DEPTH, 1, number of register stages between MEM and WB inputs/outputs (legal 1..4)
- CNT_W, 32, retired-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- MEM_Valid  in  1  MEM-side entry holds a real instruction
- MEM_Stall  in  1  freeze every stage (hold contents)
- MEM_Flush  in  1  turn every stage into a bubble
- MEM_MemtoReg  in  1  select memory data for writeback
- MEM_RegWrite  in  1  instruction writes the register file
- MEM_RegDst  in  REG_W  destination register
- MEM_ReadData  in  DATA_W  data-memory read value
- MEM_ALUResult  in  DATA_W  ALU result
- WB_Valid  out  1  last stage holds a real instruction
- WB_MemtoReg  out  1  registered MemtoReg of last stage
- WB_RegWrite  out  1  qualified write enable (see Operation)
- WB_RegDst  out  REG_W  registered destination
- WB_ReadData  out  DATA_W  registered read data
- WB_ALUResult  out  DATA_W  registered ALU result
- WB_WriteData  out  DATA_W  writeback value: WB_MemtoReg ? WB_ReadData : WB_ALUResult
- WB_Retired  out  CNT_W  count of retired instructions

## Operation
- Internal chain of DEPTH entries, stage[0] to stage[DEPTH-1]. Each entry holds {valid, MemtoReg, RegWrite, RegDst, ReadData, ALUResult}. WB_* outputs come from stage[DEPTH-1].
- Per-edge priority: reset > MEM_Flush > MEM_Stall > normal advance.
  - Reset: every entry is zeroed, including data fields. WB_Retired is set to 0.
  - Flush: every entry gets valid=0, MemtoReg=0, RegWrite=0. RegDst and data fields keep their old values. Input is not captured.
  - Stall (no flush): every entry holds. Input is not captured.
  - Advance: stage[0] captures the MEM_* inputs, with valid=MEM_Valid. Each stage[i] captures stage[i-1].
- Qualification: WB_RegWrite = stored RegWrite & WB_Valid & (WB_RegDst != 0). A write to $zero is never presented.
- WB_WriteData is a combinational mux of registered fields only. There is no combinational path from MEM_* inputs to any output.
- WB_Retired increments by 1 on an edge where reset=0, MEM_Stall=0 and WB_Valid=1.
  - Flush does not block retirement: the WB instruction is the oldest, so it commits.
  - Stall+flush together still retires, because flush wins over stall.
  - The counter wraps modulo 2^CNT_W. No saturation.
- Bubbles (valid=0) advance like normal entries and never count.

## Timing
- Latency: an input captured at edge N appears on WB_* after edge N+DEPTH-1, i.e. DEPTH edges from presentation to output, with no stalls.
- Each stall cycle adds exactly one cycle to the latency of every in-flight entry.
- Reset values: WB_Valid=0, WB_MemtoReg=0, WB_RegWrite=0, WB_RegDst=0, WB_ReadData=0, WB_ALUResult=0, WB_WriteData=0, WB_Retired=0.
- Reset asserted mid-stream discards all in-flight entries on that edge. The first post-reset capture happens on the first edge with reset=0 and no stall/flush.
- Flush takes effect at the edge where it is sampled. Outputs show the bubble in the following cycle.
- DEPTH outside 1..4 is a configuration error and must fail elaboration.

## Test plan
- Reset then stream (DEPTH=1): drive MEM_Valid=1, RegWrite=1, RegDst=8, ALUResult=0x1234, MemtoReg=0 → after 1 edge WB_RegWrite=1, WB_WriteData=0x1234, and WB_Retired=1 one edge later.
- Load path and stall (DEPTH=2): MemtoReg=1, ReadData=0xDEADBEEF, then MEM_Stall=1 for 3 cycles after capture → WB_WriteData=0xDEADBEEF appears after 2+3=5 edges, and WB_Retired does not change during the stall.
- Flush vs stall: with WB_Valid=1, assert MEM_Flush and MEM_Stall on the same cycle → next cycle WB_Valid=0, WB_RegWrite=0, and WB_Retired has incremented by 1.
- $zero suppression: MEM_Valid=1, RegWrite=1, RegDst=0 → WB_Valid=1, WB_RegWrite=0; the retired count still increments.
- Reset mid-operation (DEPTH=4): fill all 4 stages with valid entries, then assert reset for 1 cycle → all WB_* outputs=0 and WB_Retired=0; a new entry reaches WB exactly 4 edges after the first non-reset capture.
- Counter wrap (CNT_W=4): retire 17 valid instructions → WB_Retired=1.
